mash_combiner: RTL and testbench
================================

MASH_COMBINER -- requirements
Module: mash_combiner

Interface
REQ-001 SHALL have parameter OUT_W, default 4, meaning output width in bits; legal values are 4 or more.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: the s1/s2/s3 inputs carry a new modulator sample this cycle.
REQ-005 SHALL have port s1, input, 2 bits: stage-1 ternary sign, 2's complement, legal values {-1, 0, +1}.
REQ-006 SHALL have port s2, input, 2 bits: stage-2 ternary sign; its input is the stage-1 registered error, so it lags stage 1 by one sample.
REQ-007 SHALL have port s3, input, 2 bits: stage-3 ternary sign; lags stage 1 by two samples.
REQ-008 SHALL have port mode, input, 2 bits: 00 = off, 01 = MASH-1, 10 = MASH-1-1, 11 = MASH-1-1-1.
REQ-009 SHALL have port y, output, OUT_W bits, signed: the noise-cancelled multi-level output.
REQ-010 SHALL have port y_valid, output, 1 bit: y holds a valid sample.
REQ-011 SHALL have port err_illegal, output, 1 bit: sticky flag, set when an input code of 2'b10 is accepted.

Function
REQ-012 SHALL advance its history registers (s1_d1, s1_d2, s2_d1, s2_d2, s3_d1, s3_d2) only on edges where in_valid=1; at all other edges every register SHALL hold its value.
REQ-013 SHALL compute the next output as follows:
  - mode 11: y = s1_d2 + (s2_d1 - s2_d2) + (s3 - 2*s3_d1 + s3_d2).
  - mode 10: y = s1_d1 + (s2 - s2_d1).
  - mode 01: y = s1.
  - mode 00: y = 0.
  - "d1" means the previous accepted sample and "d2" the one before it.
REQ-014 SHALL sign-extend every term to OUT_W before summing. The result range is [-7, +7]; no saturation is needed for OUT_W of 4 or more.
REQ-015 SHALL register y and y_valid at the edge that accepts the sample, giving a latency of 1 clock from in_valid to y_valid (excluding the algorithmic z^-1/z^-2 alignment).
REQ-016 SHALL hold y at its last value while y_valid=0, and SHALL assert y_valid for exactly one cycle per accepted sample.
REQ-017 SHALL implement a warm-up counter wu (0..2). Each accepted sample increments wu, saturating at 2. y_valid SHALL stay 0 for accepted samples while wu < the required count: 0 for mode 01, 1 for mode 10, 2 for mode 11. y_valid SHALL always be 0 in mode 00.
REQ-018 SHALL treat any change of mode (mode differs from a registered mode_q) as a flush, taking priority over data in that cycle:
  - clear all history registers and wu;
  - set y=0 and y_valid=0;
  - discard any sample offered in that cycle;
  - update mode_q.
REQ-019 SHALL, when an accepted s1, s2 or s3 equals 2'b10 in a mode that uses that input, set err_illegal=1 and hold it until reset. The sample is still processed arithmetically as -2.
REQ-020 SHALL NOT flag inputs that the current mode does not use (for example, s3 in mode 10).
REQ-021 SHALL NOT alter any state on in_valid=0 cycles, including cycles with illegal codes or X-free garbage on s1/s2/s3.

Reset
REQ-022 SHALL, on rst=0 (asynchronously): clear all history registers, wu, y, y_valid and err_illegal to 0, and load mode_q from 00.
REQ-023 SHALL treat a nonzero mode at the first clock after reset release as a mode change, so the flush of REQ-018 applies to that first cycle.
REQ-024 SHALL discard any in-flight sample when rst asserts mid-stream, with no y_valid pulse after reset.

Verification
REQ-025 SHALL pass this scenario: mode 11 held; after the flush cycle, apply in_valid=1 for 4 samples with s1=+1, s2=0, s3=0 -> y_valid=0, 0, then 1, 1; y=+1 on the valid samples.
REQ-026 SHALL pass this scenario: mode 11; apply s3 impulse +1 at sample k, otherwise 0, with s1=s2=0 -> successive outputs +1, -2, +1, then 0.
REQ-027 SHALL pass this scenario: mode 10; apply s2 = +1, +1, -1 with s1=0 -> y = (not valid), 0, -2; err_illegal stays 0.
REQ-028 SHALL pass this scenario: switch mode 11 -> 01 mid-stream -> the next cycle gives y=0 and y_valid=0; the following accepted s1=-1 gives y=-1 with y_valid=1 immediately.
REQ-029 SHALL pass this scenario: mode 01; apply s1=2'b10 with in_valid=1 -> err_illegal=1 stays set; applying s1=2'b10 with in_valid=0 in a fresh run leaves err_illegal=0.
REQ-030 SHALL pass this scenario: assert rst low mid-stream between clock edges -> y, y_valid and err_illegal go to 0 immediately; after release the warm-up repeats.

Source files
------------

// File: rtl/mash_combiner_if.sv
// mash_combiner_if: sample bus between a MASH modulator front end and the
// noise-cancellation combiner.
//   in_valid    : s1/s2/s3 carry a new modulator sample this cycle
//   s1, s2, s3  : ternary stage signs (2's complement, -1/0/+1)
//   mode        : 00 off, 01 MASH-1, 10 MASH-1-1, 11 MASH-1-1-1
//   y           : noise-cancelled multi-level output (signed, OUT_W bits)
//   y_valid     : y holds a valid sample
//   err_illegal : sticky flag for an accepted 2'b10 code on a used input
// master = sample source, slave = combiner.
interface mash_combiner_if #(
  parameter int OUT_W = 4
);
  logic                    in_valid;
  logic [1:0]              s1;
  logic [1:0]              s2;
  logic [1:0]              s3;
  logic [1:0]              mode;
  logic signed [OUT_W-1:0] y;
  logic                    y_valid;
  logic                    err_illegal;

  modport master (
    output in_valid, s1, s2, s3, mode,
    input  y, y_valid, err_illegal
  );

  modport slave (
    input  in_valid, s1, s2, s3, mode,
    output y, y_valid, err_illegal
  );
endinterface

// File: rtl/mash_combiner.sv
// mash_combiner: digital noise-cancellation network for a 1/2/3-stage MASH
// modulator. Aligns the stage outputs with their z^-1/z^-2 history and sums
// the differentiated terms into a signed multi-level output.
//   clk : system clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : mash_combiner_if.slave (in_valid, s1..s3, mode -> y, y_valid,
//         err_illegal)
module mash_combiner #(
  parameter int OUT_W = 4
) (
  input logic            clk,
  input logic            rst,
  mash_combiner_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_OFF = 2'b00,
    MASH_1   = 2'b01,
    MASH_11  = 2'b10,
    MASH_111 = 2'b11
  } mode_e;

  mode_e                   mode_q, mode_n, mode_in;
  logic [1:0]              s1_d1, s1_d2, s2_d1, s2_d2, s3_d1, s3_d2;
  logic [1:0]              s1_d1_n, s1_d2_n, s2_d1_n, s2_d2_n, s3_d1_n, s3_d2_n;
  logic [1:0]              wu, wu_n, wu_need;
  logic signed [OUT_W-1:0] y_q, y_n, y_calc;
  logic                    yv_q, yv_n;
  logic                    err_q, err_n, illegal;

  function automatic logic signed [OUT_W-1:0] sext(input logic [1:0] v);
    return {{(OUT_W-2){v[1]}}, v};
  endfunction

  assign mode_in = mode_e'(bus.mode);

  // Combiner arithmetic and per-mode warm-up depth / input usage.
  always_comb begin
    y_calc  = '0;
    wu_need = 2'd0;
    illegal = 1'b0;
    case (mode_q)
      MASH_1: begin
        y_calc  = sext(bus.s1);
        illegal = (bus.s1 == 2'b10);
      end
      MASH_11: begin
        y_calc  = sext(s1_d1) + sext(bus.s2) - sext(s2_d1);
        wu_need = 2'd1;
        illegal = (bus.s1 == 2'b10) || (bus.s2 == 2'b10);
      end
      MASH_111: begin
        y_calc  = sext(s1_d2) + sext(s2_d1) - sext(s2_d2)
                + sext(bus.s3) - (sext(s3_d1) <<< 1) + sext(s3_d2);
        wu_need = 2'd2;
        illegal = (bus.s1 == 2'b10) || (bus.s2 == 2'b10) || (bus.s3 == 2'b10);
      end
      default: ;
    endcase
  end

  // A mode change flushes and wins over any sample offered in the same cycle.
  always_comb begin
    mode_n  = mode_q;
    s1_d1_n = s1_d1;
    s1_d2_n = s1_d2;
    s2_d1_n = s2_d1;
    s2_d2_n = s2_d2;
    s3_d1_n = s3_d1;
    s3_d2_n = s3_d2;
    wu_n    = wu;
    y_n     = y_q;
    yv_n    = 1'b0;
    err_n   = err_q;
    if (mode_in != mode_q) begin
      mode_n  = mode_in;
      s1_d1_n = '0;
      s1_d2_n = '0;
      s2_d1_n = '0;
      s2_d2_n = '0;
      s3_d1_n = '0;
      s3_d2_n = '0;
      wu_n    = '0;
      y_n     = '0;
    end else if (bus.in_valid) begin
      s1_d1_n = bus.s1;
      s1_d2_n = s1_d1;
      s2_d1_n = bus.s2;
      s2_d2_n = s2_d1;
      s3_d1_n = bus.s3;
      s3_d2_n = s3_d1;
      wu_n    = (wu == 2'd2) ? 2'd2 : wu + 2'd1;
      if (mode_q != MODE_OFF && wu >= wu_need) begin
        yv_n = 1'b1;
        y_n  = y_calc;
      end
      if (illegal) err_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_OFF;
      s1_d1  <= '0;
      s1_d2  <= '0;
      s2_d1  <= '0;
      s2_d2  <= '0;
      s3_d1  <= '0;
      s3_d2  <= '0;
      wu     <= '0;
      y_q    <= '0;
      yv_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      mode_q <= mode_n;
      s1_d1  <= s1_d1_n;
      s1_d2  <= s1_d2_n;
      s2_d1  <= s2_d1_n;
      s2_d2  <= s2_d2_n;
      s3_d1  <= s3_d1_n;
      s3_d2  <= s3_d2_n;
      wu     <= wu_n;
      y_q    <= y_n;
      yv_q   <= yv_n;
      err_q  <= err_n;
    end
  end

  assign bus.y           = y_q;
  assign bus.y_valid     = yv_q;
  assign bus.err_illegal = err_q;

endmodule

// File: tb/tb_mash_combiner.sv
// tb_mash_combiner: scenario bench for mash_combiner. Each test queues
// stimulus rows carrying the expected y/y_valid; the expectation moves to a
// scoreboard when the row is driven and is popped after the sampling edge.
module tb_mash_combiner;
  localparam int OUT_W = 4;

  typedef struct {
    int mode;
    int iv;
    int s1;
    int s2;
    int s3;
    int ey;
    bit ev;
  } row_t;

  typedef struct {
    logic signed [OUT_W-1:0] y;
    logic                    v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  row_t stim[$];
  exp_t sb[$];

  mash_combiner_if #(.OUT_W(OUT_W)) bus();

  mash_combiner #(.OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic add(input int mode, input int iv, input int s1, input int s2,
                     input int s3, input int ey, input bit ev);
    row_t r;
    r.mode = mode; r.iv = iv; r.s1 = s1; r.s2 = s2; r.s3 = s3;
    r.ey = ey; r.ev = ev;
    stim.push_back(r);
  endtask

  // Drive one row at the falling edge, queue its expectation, and return
  // just after the rising edge that consumes it.
  task automatic apply(input row_t r);
    exp_t e;
    @(negedge clk);
    bus.mode     = 2'(r.mode);
    bus.in_valid = r.iv[0];
    bus.s1       = 2'(r.s1);
    bus.s2       = 2'(r.s2);
    bus.s3       = 2'(r.s3);
    e.y = OUT_W'(r.ey);
    e.v = r.ev;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    int   i = 0;
    bus.mode = 2'b00; bus.in_valid = 1'b1;
    bus.s1 = 2'b01; bus.s2 = 2'b01; bus.s3 = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (bus.y !== 4'sd0) begin n_fail++; $display("FAIL reset_y: got %0d, expected 0", bus.y); end
    n_chk++;
    if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_y_valid: got %b, expected 0", bus.y_valid); end
    n_chk++;
    if (bus.err_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", bus.err_illegal); end
    @(negedge clk);
    rst = 1'b1;
    // Mode 00: accepted samples never produce output nor flag errors.
    add(0, 1, 1, 1, 1, 0, 0);
    add(0, 1, 2, 2, 2, 0, 0);
    while (stim.size() > 0) begin
      apply(stim.pop_front());
      e = sb.pop_front(); n_chk++;
      if (bus.y !== e.y || bus.y_valid !== e.v) begin
        n_fail++;
        $display("FAIL off_mode[%0d]: y=%0d y_valid=%b, expected y=%0d y_valid=%b", i, bus.y, bus.y_valid, e.y, e.v);
      end
      i++;
    end
    n_chk++;
    if (bus.err_illegal !== 1'b0) begin n_fail++; $display("FAIL off_mode_err: got %b, expected 0", bus.err_illegal); end
  endtask

  task automatic test_warmup;
    exp_t e;
    int   i = 0;
    add(3, 0, 0, 0, 0, 0, 0);
    add(3, 1, 1, 0, 0, 0, 0);
    add(3, 1, 1, 0, 0, 0, 0);
    add(3, 1, 1, 0, 0, 1, 1);
    add(3, 1, 1, 0, 0, 1, 1);
    while (stim.size() > 0) begin
      apply(stim.pop_front());
      e = sb.pop_front(); n_chk++;
      if (bus.y !== e.y || bus.y_valid !== e.v) begin
        n_fail++;
        $display("FAIL warmup[%0d]: y=%0d y_valid=%b, expected y=%0d y_valid=%b", i, bus.y, bus.y_valid, e.y, e.v);
      end
      i++;
    end
  endtask

  task automatic test_impulse;
    exp_t e;
    int   i = 0;
    add(0, 0, 0, 0, 0, 0, 0);
    add(3, 0, 0, 0, 0, 0, 0);
    add(3, 1, 0, 0, 0, 0, 0);
    add(3, 1, 0, 0, 0, 0, 0);
    add(3, 1, 0, 0, 1, 1, 1);
    add(3, 1, 0, 0, 0, -2, 1);
    add(3, 0, 1, 1, 1, -2, 0);   // idle with garbage: history must not move
    add(3, 1, 0, 0, 0, 1, 1);
    add(3, 1, 0, 0, 0, 0, 1);
    while (stim.size() > 0) begin
      apply(stim.pop_front());
      e = sb.pop_front(); n_chk++;
      if (bus.y !== e.y || bus.y_valid !== e.v) begin
        n_fail++;
        $display("FAIL impulse[%0d]: y=%0d y_valid=%b, expected y=%0d y_valid=%b", i, bus.y, bus.y_valid, e.y, e.v);
      end
      i++;
    end
  endtask

  task automatic test_mash11;
    exp_t e;
    int   i = 0;
    add(2, 1, 0, 1, 0, 0, 0);    // flush cycle: offered sample is discarded
    add(2, 1, 0, 1, 0, 0, 0);
    add(2, 1, 0, 1, 0, 0, 1);
    add(2, 1, 0, -1, 0, -2, 1);
    while (stim.size() > 0) begin
      apply(stim.pop_front());
      e = sb.pop_front(); n_chk++;
      if (bus.y !== e.y || bus.y_valid !== e.v) begin
        n_fail++;
        $display("FAIL mash11[%0d]: y=%0d y_valid=%b, expected y=%0d y_valid=%b", i, bus.y, bus.y_valid, e.y, e.v);
      end
      i++;
    end
    n_chk++;
    if (bus.err_illegal !== 1'b0) begin n_fail++; $display("FAIL mash11_err: got %b, expected 0", bus.err_illegal); end
  endtask

  task automatic test_range;
    exp_t e;
    int   i = 0;
    add(3, 0, 0, 0, 0, 0, 0);
    add(3, 1, 1, -1, 1, 0, 0);
    add(3, 1, 0, 1, -1, 0, 0);
    add(3, 1, 0, 0, 1, 7, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    add(3, 0, 0, 0, 0, 0, 0);
    add(3, 1, -1, 1, -1, 0, 0);
    add(3, 1, 0, -1, 1, 0, 0);
    add(3, 1, 0, 0, -1, -7, 1);
    while (stim.size() > 0) begin
      apply(stim.pop_front());
      e = sb.pop_front(); n_chk++;
      if (bus.y !== e.y || bus.y_valid !== e.v) begin
        n_fail++;
        $display("FAIL range[%0d]: y=%0d y_valid=%b, expected y=%0d y_valid=%b", i, bus.y, bus.y_valid, e.y, e.v);
      end
      i++;
    end
  endtask

  task automatic test_mode_switch;
    exp_t e;
    int   i = 0;
    add(0, 0, 0, 0, 0, 0, 0);
    add(3, 0, 0, 0, 0, 0, 0);
    add(3, 1, 1, 0, 0, 0, 0);
    add(3, 1, 1, 0, 0, 0, 0);
    add(3, 1, 1, 0, 0, 1, 1);
    add(1, 1, 1, 0, 0, 0, 0);
    add(1, 1, -1, 0, 0, -1, 1);
    while (stim.size() > 0) begin
      apply(stim.pop_front());
      e = sb.pop_front(); n_chk++;
      if (bus.y !== e.y || bus.y_valid !== e.v) begin
        n_fail++;
        $display("FAIL mode_switch[%0d]: y=%0d y_valid=%b, expected y=%0d y_valid=%b", i, bus.y, bus.y_valid, e.y, e.v);
      end
      i++;
    end
  endtask

  task automatic test_illegal;
    exp_t e;
    int   i = 0;
    @(negedge clk);
    rst = 1'b0;
    bus.mode = 2'b00; bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    add(2, 0, 0, 0, 0, 0, 0);
    add(2, 1, 0, 0, 2, 0, 0);    // s3 unused in mode 10
    add(2, 1, 0, 1, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 2, 2, 2, 0, 0);    // illegal codes, not accepted
    while (stim.size() > 0) begin
      apply(stim.pop_front());
      e = sb.pop_front(); n_chk++;
      if (bus.y !== e.y || bus.y_valid !== e.v) begin
        n_fail++;
        $display("FAIL illegal_a[%0d]: y=%0d y_valid=%b, expected y=%0d y_valid=%b", i, bus.y, bus.y_valid, e.y, e.v);
      end
      i++;
    end
    n_chk++;
    if (bus.err_illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_not_accepted: got %b, expected 0", bus.err_illegal); end
    add(1, 1, 2, 0, 0, -2, 1);
    add(1, 1, 1, 0, 0, 1, 1);
    while (stim.size() > 0) begin
      apply(stim.pop_front());
      e = sb.pop_front(); n_chk++;
      if (bus.y !== e.y || bus.y_valid !== e.v) begin
        n_fail++;
        $display("FAIL illegal_b[%0d]: y=%0d y_valid=%b, expected y=%0d y_valid=%b", i, bus.y, bus.y_valid, e.y, e.v);
      end
      i++;
    end
    n_chk++;
    if (bus.err_illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky: got %b, expected 1", bus.err_illegal); end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int   i = 0;
    add(3, 0, 0, 0, 0, 0, 0);
    add(3, 1, 1, 0, 0, 0, 0);
    add(3, 1, 1, 0, 0, 0, 0);
    add(3, 1, 1, 0, 0, 1, 1);
    while (stim.size() > 0) begin
      apply(stim.pop_front());
      e = sb.pop_front();
      i++;
    end
    // Sample in flight, reset asserted between edges.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.s1 = 2'b01;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_chk++;
    if (bus.y !== 4'sd0) begin n_fail++; $display("FAIL mid_reset_y: got %0d, expected 0", bus.y); end
    n_chk++;
    if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_y_valid: got %b, expected 0", bus.y_valid); end
    n_chk++;
    if (bus.err_illegal !== 1'b0) begin n_fail++; $display("FAIL mid_reset_err: got %b, expected 0", bus.err_illegal); end
    @(posedge clk);
    #2;
    rst = 1'b1;
    i = 0;
    add(3, 1, 1, 0, 0, 0, 0);    // first edge after release is a flush
    add(3, 1, 1, 0, 0, 0, 0);
    add(3, 1, 1, 0, 0, 0, 0);
    add(3, 1, 1, 0, 0, 1, 1);
    while (stim.size() > 0) begin
      apply(stim.pop_front());
      e = sb.pop_front(); n_chk++;
      if (bus.y !== e.y || bus.y_valid !== e.v) begin
        n_fail++;
        $display("FAIL after_reset[%0d]: y=%0d y_valid=%b, expected y=%0d y_valid=%b", i, bus.y, bus.y_valid, e.y, e.v);
      end
      i++;
    end
  endtask

  initial begin
    bus.mode = 2'b00; bus.in_valid = 1'b0;
    bus.s1 = 2'b00; bus.s2 = 2'b00; bus.s3 = 2'b00;
    test_reset();
    test_warmup();
    test_impulse();
    test_mash11();
    test_range();
    test_mode_switch();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
